// File: rtl/pic_pkg.sv
// Shared types, OCW2 command codes and level helpers for the 8259A-compatible PIC.
package pic_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      ACK2
   } seq_state_t;

   // OCW2 {R, SL, EOI}
   localparam logic [2:0] OCW2_CLR_AROT = 3'b000;
   localparam logic [2:0] OCW2_NS_EOI   = 3'b001;
   localparam logic [2:0] OCW2_NOP      = 3'b010;
   localparam logic [2:0] OCW2_SP_EOI   = 3'b011;
   localparam logic [2:0] OCW2_SET_AROT = 3'b100;
   localparam logic [2:0] OCW2_ROT_NS   = 3'b101;
   localparam logic [2:0] OCW2_SET_PRI  = 3'b110;
   localparam logic [2:0] OCW2_ROT_SP   = 3'b111;

   function automatic logic [2:0] encode(input logic [7:0] onehot);
      logic [2:0] lvl;
      lvl = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (onehot[i]) lvl = 3'(i);
      end
      return lvl;
   endfunction

   function automatic logic [7:0] decode(input logic [2:0] lvl);
      return 8'b1 << lvl;
   endfunction

endpackage

// File: rtl/isr_priority_find.sv
// Highest-priority in-service bit under the current rotation; scan starts one
// level above the lowest-priority level and wraps around to it.
module isr_priority_find
   import pic_pkg::*;
(
   input  logic [7:0] isr,
   input  logic [2:0] priority_rotate,
   output logic [7:0] highest
);

   logic [2:0] lvl;
   logic       found;

   always_comb begin
      highest = '0;
      found   = 1'b0;
      lvl     = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         lvl = priority_rotate + 3'd1 + 3'(i);
         if (!found && isr[lvl]) begin
            highest = decode(lvl);
            found   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/interrupt_sequencer.sv
// In-service side of the PIC: INT/INTA handshake (8086 mode), ISR, rotation
// pointer and OCW2 EOI/rotate command execution.
module interrupt_sequencer
   import pic_pkg::*;
#(
   parameter int unsigned VECTOR_W       = 8,
   parameter logic [2:0]  SPURIOUS_LEVEL = 3'd7
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [7:0]          interrupt_in,
   input  logic                inta_pulse,
   input  logic                ocw2_valid,
   input  logic [2:0]          ocw2_cmd,
   input  logic [2:0]          ocw2_level,
   input  logic                auto_eoi,
   input  logic [4:0]          vector_base,
   output logic                int_out,
   output logic [7:0]          isr,
   output logic [2:0]          priority_rotate,
   output logic [7:0]          highest_level_in_service,
   output logic [7:0]          clear_irr,
   output logic [VECTOR_W-1:0] vector_out,
   output logic                vector_valid
);

   seq_state_t state, state_n;
   logic [2:0] level_q, level_n;
   logic       spurious_q, spurious_n;
   logic       auto_rotate, auto_rotate_n;
   logic [2:0] rotate_n;
   logic [7:0] isr_set, isr_clr;
   logic [7:0] clear_irr_n;
   logic       vec_fire;

   isr_priority_find u_find (
      .isr             (isr),
      .priority_rotate (priority_rotate),
      .highest         (highest_level_in_service)
   );

   assign int_out = (state == REQ);

   always_comb begin
      state_n       = state;
      level_n       = level_q;
      spurious_n    = spurious_q;
      auto_rotate_n = auto_rotate;
      rotate_n      = priority_rotate;
      isr_set       = '0;
      isr_clr       = '0;
      clear_irr_n   = '0;
      vec_fire      = 1'b0;

      case (state)
         IDLE: begin
            if (|interrupt_in) state_n = REQ;
         end
         REQ: begin
            if (inta_pulse) begin
               state_n = ACK2;
               if (|interrupt_in) begin
                  level_n     = encode(interrupt_in);
                  spurious_n  = 1'b0;
                  isr_set     = decode(level_n);
                  clear_irr_n = decode(level_n);
               end else begin
                  level_n    = SPURIOUS_LEVEL;
                  spurious_n = 1'b1;
               end
            end
         end
         ACK2: begin
            if (inta_pulse) begin
               vec_fire = 1'b1;
               state_n  = IDLE;
               if (auto_eoi && !spurious_q) begin
                  isr_clr = decode(level_q);
                  if (auto_rotate) rotate_n = level_q;
               end
            end
         end
         default: state_n = IDLE;
      endcase

      // Evaluated after the AEOI path so an OCW2 rotation write takes precedence.
      if (ocw2_valid) begin
         case (ocw2_cmd)
            OCW2_NS_EOI: isr_clr = isr_clr | highest_level_in_service;
            OCW2_SP_EOI: isr_clr = isr_clr | decode(ocw2_level);
            OCW2_ROT_NS: begin
               if (|highest_level_in_service) begin
                  isr_clr  = isr_clr | highest_level_in_service;
                  rotate_n = encode(highest_level_in_service);
               end
            end
            OCW2_ROT_SP: begin
               isr_clr  = isr_clr | decode(ocw2_level);
               rotate_n = ocw2_level;
            end
            OCW2_SET_PRI:  rotate_n = ocw2_level;
            OCW2_SET_AROT: auto_rotate_n = 1'b1;
            OCW2_CLR_AROT: auto_rotate_n = 1'b0;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         isr             <= '0;
         priority_rotate <= 3'd7;
         auto_rotate     <= 1'b0;
         level_q         <= '0;
         spurious_q      <= 1'b0;
         clear_irr       <= '0;
         vector_out      <= '0;
         vector_valid    <= 1'b0;
      end else begin
         state           <= state_n;
         // Clear first, then set: an acknowledge wins over an EOI on the same bit.
         isr             <= (isr & ~isr_clr) | isr_set;
         priority_rotate <= rotate_n;
         auto_rotate     <= auto_rotate_n;
         level_q         <= level_n;
         spurious_q      <= spurious_n;
         clear_irr       <= clear_irr_n;
         vector_valid    <= vec_fire;
         if (vec_fire) vector_out <= VECTOR_W'({vector_base, level_q});
      end
   end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Scoreboard bench for interrupt_sequencer: a behavioural PIC model predicts
// vectors, IRR clears, ISR and rotation; a monitor checks DUT strobes.
module tb_interrupt_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] interrupt_in;
   logic       inta_pulse;
   logic       ocw2_valid;
   logic [2:0] ocw2_cmd;
   logic [2:0] ocw2_level;
   logic       auto_eoi;
   logic [4:0] vector_base;
   logic       int_out;
   logic [7:0] isr;
   logic [2:0] priority_rotate;
   logic [7:0] highest_level_in_service;
   logic [7:0] clear_irr;
   logic [7:0] vector_out;
   logic       vector_valid;

   interrupt_sequencer #(.VECTOR_W(8), .SPURIOUS_LEVEL(3'd7)) dut (
      .clk                      (clk),
      .rst                      (rst),
      .interrupt_in             (interrupt_in),
      .inta_pulse               (inta_pulse),
      .ocw2_valid               (ocw2_valid),
      .ocw2_cmd                 (ocw2_cmd),
      .ocw2_level               (ocw2_level),
      .auto_eoi                 (auto_eoi),
      .vector_base              (vector_base),
      .int_out                  (int_out),
      .isr                      (isr),
      .priority_rotate          (priority_rotate),
      .highest_level_in_service (highest_level_in_service),
      .clear_irr                (clear_irr),
      .vector_out               (vector_out),
      .vector_valid             (vector_valid)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] vec;
      logic [7:0] isr;
      logic [2:0] rot;
   } vexp_t;

   typedef struct packed {
      logic [7:0] clr;
      logic [7:0] isr;
   } cexp_t;

   vexp_t vq[$];
   cexp_t cq[$];

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   logic [7:0] m_isr;
   int         m_rot;
   bit         m_arot;

   function automatic int m_high(input logic [7:0] s, input int r);
      for (int i = 1; i <= 8; i++) begin
         int l;
         l = (r + i) % 8;
         if (s[l]) return l;
      end
      return -1;
   endfunction

   function automatic logic [7:0] m_high_onehot(input logic [7:0] s, input int r);
      int h;
      h = m_high(s, r);
      return (h < 0) ? 8'h00 : (8'h01 << h);
   endfunction

   task automatic m_ocw(input int cmd, input int lvl, input logic [7:0] s,
                        output logic [7:0] clr, output int rw);
      int h;
      h   = m_high(s, m_rot);
      clr = '0;
      rw  = -1;
      case (cmd)
         1: if (h >= 0) clr = 8'h01 << h;
         3: clr = 8'h01 << lvl;
         5: if (h >= 0) begin clr = 8'h01 << h; rw = h; end
         7: begin clr = 8'h01 << lvl; rw = lvl; end
         6: rw = lvl;
         4: m_arot = 1'b1;
         0: m_arot = 1'b0;
         default: ;
      endcase
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_state(input string name);
      chk({name, "_isr"}, 32'(isr), 32'(m_isr));
      chk({name, "_rot"}, 32'(priority_rotate), 32'(m_rot));
      chk({name, "_hlis"}, 32'(highest_level_in_service), 32'(m_high_onehot(m_isr, m_rot)));
   endtask

   task automatic do_ocw(input int cmd, input int lvl);
      logic [7:0] clr;
      int rw;
      m_ocw(cmd, lvl, m_isr, clr, rw);
      m_isr = m_isr & ~clr;
      if (rw >= 0) m_rot = rw;
      ocw2_valid = 1'b1;
      ocw2_cmd   = 3'(cmd);
      ocw2_level = 3'(lvl);
      tick;
      ocw2_valid = 1'b0;
      chk_state("ocw");
   endtask

   task automatic do_irq(input int lvl, input bit spur, input bit aeoi,
                         input bit o1, input int c1, input int l1,
                         input bit o2, input int c2, input int l2);
      logic [7:0] bitv, clr, aclr;
      int rw, rot_a, vlvl;
      bitv     = 8'h01 << lvl;
      auto_eoi = aeoi;
      chk("int_idle", 32'(int_out), 32'd0);
      interrupt_in = bitv;
      tick;
      chk("int_rise", 32'(int_out), 32'd1);

      // First INTA, optionally racing an OCW2 write
      if (spur) interrupt_in = '0;
      inta_pulse = 1'b1;
      if (o1) begin ocw2_valid = 1'b1; ocw2_cmd = 3'(c1); ocw2_level = 3'(l1); end
      clr = '0;
      rw  = -1;
      if (o1) m_ocw(c1, l1, m_isr, clr, rw);
      m_isr = m_isr & ~clr;
      if (rw >= 0) m_rot = rw;
      if (!spur) begin
         m_isr = m_isr | bitv;
         cq.push_back('{clr: bitv, isr: m_isr});
      end
      tick;
      inta_pulse   = 1'b0;
      ocw2_valid   = 1'b0;
      interrupt_in = '0;
      chk("int_fall", 32'(int_out), 32'd0);
      chk_state("inta1");
      tick;

      // Second INTA
      inta_pulse = 1'b1;
      if (o2) begin ocw2_valid = 1'b1; ocw2_cmd = 3'(c2); ocw2_level = 3'(l2); end
      aclr  = '0;
      rot_a = m_rot;
      if (aeoi && !spur) begin
         aclr = bitv;
         if (m_arot) rot_a = lvl;
      end
      clr = '0;
      rw  = -1;
      if (o2) m_ocw(c2, l2, m_isr, clr, rw);
      m_isr = m_isr & ~(clr | aclr);
      m_rot = (rw >= 0) ? rw : rot_a;
      vlvl  = spur ? 7 : lvl;
      vq.push_back('{vec: {vector_base, 3'(vlvl)}, isr: m_isr, rot: 3'(m_rot)});
      tick;
      inta_pulse = 1'b0;
      ocw2_valid = 1'b0;
      chk_state("inta2");
      tick;
   endtask

   // Monitor: every strobe from the DUT must match the oldest prediction
   always @(negedge clk) begin
      if (!rst) begin
         if (vector_valid) begin
            n_vec++;
            if (vq.size() == 0) begin
               n_err++;
               $display("FAIL vec_unexpected: got vector %0h with no vector pending", vector_out);
            end else begin
               vexp_t e;
               e = vq.pop_front();
               if (vector_out !== e.vec || isr !== e.isr || priority_rotate !== e.rot) begin
                  n_err++;
                  $display("FAIL vec: got vec=%0h isr=%0h rot=%0d expected vec=%0h isr=%0h rot=%0d",
                           vector_out, isr, priority_rotate, e.vec, e.isr, e.rot);
               end
            end
         end
         if (clear_irr != 8'h00) begin
            n_vec++;
            if (cq.size() == 0) begin
               n_err++;
               $display("FAIL clr_unexpected: got clear_irr %0h with no clear pending", clear_irr);
            end else begin
               cexp_t c;
               c = cq.pop_front();
               if (clear_irr !== c.clr || isr !== c.isr) begin
                  n_err++;
                  $display("FAIL clr: got clear_irr=%0h isr=%0h expected clear_irr=%0h isr=%0h",
                           clear_irr, isr, c.clr, c.isr);
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst          = 1'b1;
      interrupt_in = '0;
      inta_pulse   = 1'b0;
      ocw2_valid   = 1'b0;
      ocw2_cmd     = '0;
      ocw2_level   = '0;
      auto_eoi     = 1'b0;
      vector_base  = 5'h10;
      m_isr        = '0;
      m_rot        = 7;
      m_arot       = 1'b0;
      tick;
      tick;
      rst = 1'b0;
      chk("rst_int", 32'(int_out), 32'd0);
      chk("rst_vv", 32'(vector_valid), 32'd0);
      chk("rst_vec", 32'(vector_out), 32'd0);
      chk("rst_clr", 32'(clear_irr), 32'd0);
      chk_state("rst");

      // Fixed priority acknowledge of IR2
      do_irq(2, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("tp_vec82", 32'(vector_out), 32'h82);
      chk("tp_isr04", 32'(isr), 32'h04);
      do_ocw(3, 2);

      // Spurious: request vanishes before first INTA
      do_irq(0, 1, 0, 0, 0, 0, 0, 0, 0);
      chk("tp_spur_vec", 32'(vector_out), 32'h87);
      chk("tp_spur_isr", 32'(isr), 32'h00);

      // Non-specific EOI and rotate on non-specific EOI
      do_irq(1, 0, 0, 0, 0, 0, 0, 0, 0);
      do_irq(3, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("tp_isr0a", 32'(isr), 32'h0A);
      do_ocw(1, 0);
      chk("tp_nseoi", 32'(isr), 32'h08);
      do_irq(1, 0, 0, 0, 0, 0, 0, 0, 0);
      do_ocw(6, 1);
      do_ocw(5, 0);
      chk("tp_rotns_isr", 32'(isr), 32'h02);
      chk("tp_rotns_rot", 32'(priority_rotate), 32'd3);
      do_ocw(3, 1);
      do_ocw(1, 0);
      do_ocw(5, 0);
      chk("tp_empty_rot", 32'(priority_rotate), 32'd3);

      // AEOI with auto-rotate
      do_ocw(4, 0);
      do_irq(5, 0, 1, 0, 0, 0, 0, 0, 0);
      chk("tp_aeoi_isr", 32'(isr), 32'h00);
      chk("tp_aeoi_rot", 32'(priority_rotate), 32'd5);
      // Priority write racing an AEOI auto-rotate
      do_irq(4, 0, 1, 0, 0, 0, 1, 6, 1);
      chk("tp_race_rot", 32'(priority_rotate), 32'd1);

      // Acknowledge and specific EOI on the same bit in the same cycle
      do_ocw(0, 0);
      do_ocw(6, 7);
      do_irq(2, 0, 0, 0, 0, 0, 0, 0, 0);
      do_irq(2, 0, 0, 1, 3, 2, 0, 0, 0);
      chk("tp_setwins", 32'(isr), 32'h04);

      // Reset while waiting for the second INTA
      interrupt_in = 8'h08;
      tick;
      inta_pulse = 1'b1;
      m_isr = m_isr | 8'h08;
      cq.push_back('{clr: 8'h08, isr: m_isr});
      tick;
      inta_pulse   = 1'b0;
      interrupt_in = '0;
      tick;
      rst = 1'b1;
      tick;
      rst    = 1'b0;
      m_isr  = '0;
      m_rot  = 7;
      m_arot = 1'b0;
      chk("rst2_int", 32'(int_out), 32'd0);
      chk_state("rst2");
      inta_pulse = 1'b1;
      tick;
      inta_pulse = 1'b0;
      chk("rst2_novec", 32'(vector_valid), 32'd0);
      tick;

      // Randomised mix of acknowledges and OCW2 commands
      for (int it = 0; it < 60; it++) begin
         if ($urandom_range(0, 2) == 0) begin
            do_ocw(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
         end else begin
            vector_base = 5'($urandom);
            do_irq(int'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0),
                   1'($urandom), ($urandom_range(0, 3) == 0),
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   ($urandom_range(0, 3) == 0),
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
         end
      end

      repeat (4) tick;
      chk("vq_drained", 32'(vq.size()), 32'd0);
      chk("cq_drained", 32'(cq.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
Controls the in-service side of the 8259A-compatible PIC. Takes the one-hot winner from PriorityResolver, raises INT, and runs the two-pulse INTA sequence (8086 mode). Owns the ISR register, the priority rotation pointer and the highest-level-in-service vector, and executes OCW2 EOI/rotate commands. Its outputs feed back into PriorityResolver and the IRR block.

Parameters:
- VECTOR_W, 8, width of the vector byte driven on the second INTA.
- SPURIOUS_LEVEL, 3'd7, level reported when the request disappears before the first INTA.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- interrupt_in  in  8  one-hot resolved request from PriorityResolver (0 = none).
- inta_pulse  in  1  one-cycle strobe per INTA falling edge; already synchronised upstream.
- ocw2_valid  in  1  one-cycle strobe: OCW2 written.
- ocw2_cmd  in  3  {R, SL, EOI} field of OCW2.
- ocw2_level  in  3  L2..L0 field of OCW2.
- auto_eoi  in  1  ICW4 AEOI mode.
- vector_base  in  5  ICW2 T7..T3.
- int_out  out  1  INT to the CPU.
- isr  out  8  in-service register.
- priority_rotate  out  3  lowest-priority level; 7 = fixed priority (IR0 highest).
- highest_level_in_service  out  8  one-hot highest-priority ISR bit under current rotation; 0 if ISR empty.
- clear_irr  out  8  one-cycle pulse clearing the acknowledged IRR bit.
- vector_out  out  VECTOR_W  vector byte.
- vector_valid  out  1  one-cycle strobe qualifying vector_out.

Behaviour:
- Reset: state IDLE, int_out=0, isr=0, priority_rotate=7, auto_rotate=0, latched level=0, clear_irr=0, vector_out=0, vector_valid=0.
- FSM states:
  - IDLE: if interrupt_in!=0, go REQ and set int_out=1 next cycle. inta_pulse is ignored.
  - REQ: int_out=1. On inta_pulse:
    - interrupt_in!=0: latch level=encode(interrupt_in), set isr[level], pulse clear_irr[level], go ACK2.
    - interrupt_in==0: latch SPURIOUS_LEVEL, no ISR or IRR change, go ACK2.
    - In both cases int_out=0 from the next cycle.
  - ACK2: on inta_pulse, vector_out={vector_base, level} and vector_valid=1 for one cycle.
    - If auto_eoi: clear isr[level] in the same cycle. If auto_rotate is also set, priority_rotate=level.
    - A spurious level never touches ISR.
    - Go IDLE.
- Latency: INT rises 1 cycle after interrupt_in goes non-zero. ISR set and clear_irr occur on the cycle after the first inta_pulse. The vector appears the cycle after the second inta_pulse.
- OCW2 (ocw2_valid) by cmd:
  - 001: non-specific EOI, clear the bit in highest_level_in_service.
  - 011: specific EOI, clear isr[ocw2_level].
  - 101: rotate on non-specific EOI, clear the highest bit and set priority_rotate to that level.
  - 111: rotate on specific EOI, clear isr[ocw2_level] and set priority_rotate=ocw2_level.
  - 110: set priority, priority_rotate=ocw2_level.
  - 100: auto_rotate=1.
  - 000: auto_rotate=0.
  - 010: no-op.
  - Non-specific EOI with an empty ISR: no change; a rotate command leaves priority_rotate unchanged.
- Simultaneous events:
  - EOI clears are computed on the current ISR. An INTA set in the same cycle is applied after the clear, so the set wins on the same bit.
  - OCW2 priority writes win over an AEOI auto-rotate in the same cycle.
- highest_level_in_service: combinational from registered isr and priority_rotate. Scan starts at level (priority_rotate+1) mod 8, wrapping to priority_rotate.
- Modulo-8 arithmetic throughout; level 7+1 wraps to 0.
- rst mid-sequence (REQ/ACK2): abort and return to reset values. No vector is issued.

Decomposition:
- Package pic_pkg:
  - state enum IDLE/REQ/ACK2.
  - OCW2 command constants: OCW2_NS_EOI, OCW2_SP_EOI, OCW2_ROT_NS, OCW2_ROT_SP, OCW2_SET_PRI, OCW2_SET_AROT, OCW2_CLR_AROT, OCW2_NOP.
  - encode/decode functions for one-hot <-> 3-bit level.
- Sub-module isr_priority_find: rotated highest-in-service search. It is also reused by the poll-command logic.

Test Plan:
- Fixed priority, interrupt_in=8'h04, vector_base=5'h10, two INTA pulses -> int_out rises 1 cycle later; isr=8'h04 and clear_irr=8'h04 after INTA1; vector_out=8'h82 with vector_valid after INTA2.
- Spurious: interrupt_in=8'h01 drops to 0 before INTA1 -> isr stays 0, no clear_irr, vector_out={base,3'd7}.
- isr=8'h0A, non-specific EOI -> isr=8'h08. With priority_rotate=1, isr=8'h0A, cmd 101 -> isr=8'h02 and priority_rotate=3.
- auto_eoi=1, auto_rotate=1 (cmd 100), acknowledge IR5 -> isr returns to 0 on INTA2 and priority_rotate=5.
- Same-cycle INTA1 on IR2 and specific EOI on level 2 with isr=8'h04 -> isr=8'h04 (set wins).
- rst asserted in ACK2 -> next cycle state IDLE, isr=0, priority_rotate=7, no vector_valid on a subsequent inta_pulse.
